gsensor_spi_ctrl: RTL and testbench

//  Sequencer for spi_serdes talking to the on-board ADXL345 accelerometer. After reset it

---
 rtl/gsensor_pkg.sv | 55 +++++
 rtl/gsensor_poll_trigger.sv | 54 +++++
 rtl/gsensor_spi_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gsensor_spi_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_pkg.sv
// rtl/gsensor_pkg.sv - shared constants for the ADXL345 SPI sequencer
// Purpose: FSM state encodings, ADXL345 register addresses, init table and
//          SPI command word helper used by gsensor_spi_ctrl.
// Config:  GSENSOR_INT_EN selects the INT_ENABLE init value (DATA_READY on INT1).
package gsensor_pkg;

  localparam logic [3:0] ST_BOOT      = 4'd0;
  localparam logic [3:0] ST_INIT_REQ  = 4'd1;
  localparam logic [3:0] ST_INIT_WAIT = 4'd2;
  localparam logic [3:0] ST_INIT_GAP  = 4'd3;
  localparam logic [3:0] ST_POLL_IDLE = 4'd4;
  localparam logic [3:0] ST_RD_REQ    = 4'd5;
  localparam logic [3:0] ST_RD_WAIT   = 4'd6;
  localparam logic [3:0] ST_RD_GAP    = 4'd7;
  localparam logic [3:0] ST_PUBLISH   = 4'd8;

  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;

`ifdef GSENSOR_INT_EN
  localparam logic [7:0] INT_ENABLE_VAL = 8'h80;
`else
  localparam logic [7:0] INT_ENABLE_VAL = 8'h00;
`endif

  localparam int INIT_LEN  = 5;
  localparam int READ_LEN  = 6;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] wdata;
  } reg_write_t;

  function automatic reg_write_t init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return {ADDR_DATA_FORMAT, 8'h0B};
      3'd1:    return {ADDR_BW_RATE,     8'h0A};
      3'd2:    return {ADDR_INT_MAP,     8'h00};
      3'd3:    return {ADDR_INT_ENABLE,  INT_ENABLE_VAL};
      3'd4:    return {ADDR_POWER_CTL,   8'h08};
      default: return '0;
    endcase
  endfunction

  // Command word for spi_serdes: R/nW, MB (never used), 6-bit address, data.
  function automatic logic [15:0] spi_word(input logic rnw, input logic [5:0] addr,
                                           input logic [7:0] wdata);
    return {rnw, 1'b0, addr, wdata};
  endfunction

endpackage

// File: rtl/gsensor_poll_trigger.sv
// rtl/gsensor_poll_trigger.sv - one-cycle poll tick from a timer or the INT1 pin
// Purpose: produces the burst-read trigger for gsensor_spi_ctrl.
// Ports:   spi_clk, reset_n (async active-low), enable (held low until init is done),
//          int1 (only with GSENSOR_INT_EN), tick (one-cycle pulse out).
// Config:  GSENSOR_INT_EN defined -> 2-flop synchronizer + rising-edge detect on int1,
//          no period counter. Undefined -> free-running UPDATE_PERIOD counter.
module gsensor_poll_trigger #(
  parameter int UPDATE_PERIOD = 20000
) (
  input  logic spi_clk,
  input  logic reset_n,
  input  logic enable,
`ifdef GSENSOR_INT_EN
  input  logic int1,
`endif
  output logic tick
);

`ifdef GSENSOR_INT_EN
  // sync[0..1] synchronize, sync[2] holds the previous synchronized level.
  logic [2:0] sync;

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], int1};
    end
  end

  assign tick = enable & sync[1] & ~sync[2];
`else
  localparam int CW = $clog2(UPDATE_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(UPDATE_PERIOD - 1);

  logic [CW-1:0] cnt;

  // Held at zero until enabled so the phase is referenced to init completion.
  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);
`endif

endmodule

// File: rtl/gsensor_spi_ctrl.sv
// rtl/gsensor_spi_ctrl.sv - ADXL345 init and periodic XYZ poll sequencer for spi_serdes
// Purpose: writes the init table after a boot delay, then on each poll trigger reads
//          DATAX0..DATAZ1 as six single-byte reads and publishes signed X/Y/Z together.
// Ports:   spi_clk, reset_n (async active-low); start/data_tx out and done/data_rx in
//          form the spi_serdes handshake; init_done level; data_x/y/z sample words;
//          data_valid one-cycle pulse; overrun sticky dropped-trigger flag;
//          G_SENSOR_INT1 input only when GSENSOR_INT_EN is defined.
// Config:  GSENSOR_INT_EN selects INT1-driven polling instead of the internal timer.
module gsensor_spi_ctrl
  import gsensor_pkg::*;
#(
  parameter int UPDATE_PERIOD = 20000,
  parameter int INIT_DELAY    = 2000
) (
  input  logic        spi_clk,
  input  logic        reset_n,
  output logic        start,
  output logic [15:0] data_tx,
  input  logic        done,
  input  logic [7:0]  data_rx,
  output logic        init_done,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_valid,
`ifdef GSENSOR_INT_EN
  input  logic        G_SENSOR_INT1,
`endif
  output logic        overrun
);

  localparam int BW = $clog2(INIT_DELAY + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(INIT_DELAY - 1);

  logic [3:0]    state;
  logic [BW-1:0] boot_cnt;
  logic [2:0]    idx;
  logic [47:0]   shadow;
  logic          pending;
  logic          tick;
  reg_write_t    init_cur;

  assign init_cur = init_entry(idx);

  gsensor_poll_trigger #(
    .UPDATE_PERIOD(UPDATE_PERIOD)
  ) u_trigger (
    .spi_clk (spi_clk),
    .reset_n (reset_n),
    .enable  (init_done),
`ifdef GSENSOR_INT_EN
    .int1    (G_SENSOR_INT1),
`endif
    .tick    (tick)
  );

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BOOT;
      boot_cnt   <= '0;
      idx        <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      start      <= 1'b0;
      data_tx    <= '0;
      init_done  <= 1'b0;
      data_x     <= '0;
      data_y     <= '0;
      data_z     <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // Triggers outside POLL_IDLE (including PUBLISH) queue one deep; a second is lost.
      if (tick && state != ST_POLL_IDLE) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            idx   <= '0;
            state <= ST_INIT_REQ;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end

        ST_INIT_REQ: begin
          data_tx <= spi_word(1'b0, init_cur.addr, init_cur.wdata);
          start   <= 1'b1;
          state   <= ST_INIT_WAIT;
        end

        ST_INIT_WAIT: begin
          if (done) begin
            start <= 1'b0;
            state <= ST_INIT_GAP;
          end
        end

        // Never re-raise start while spi_serdes still shows done.
        ST_INIT_GAP: begin
          if (!done) begin
            if (idx == 3'(INIT_LEN - 1)) begin
              init_done <= 1'b1;
              idx       <= '0;
              state     <= ST_POLL_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_INIT_REQ;
            end
          end
        end

        ST_POLL_IDLE: begin
          if (tick || pending) begin
            idx     <= '0;
            // A fresh tick landing on a pending one still leaves one queued burst.
            pending <= tick & pending;
            state   <= ST_RD_REQ;
          end
        end

        ST_RD_REQ: begin
          data_tx <= spi_word(1'b1, ADDR_DATAX0 + {3'b000, idx}, 8'h00);
          start   <= 1'b1;
          state   <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (done) begin
            shadow[{idx, 3'b000} +: 8] <= data_rx;
            start <= 1'b0;
            state <= ST_RD_GAP;
          end
        end

        ST_RD_GAP: begin
          if (!done) begin
            if (idx == 3'(READ_LEN - 1)) begin
              data_x     <= shadow[15:0];
              data_y     <= shadow[31:16];
              data_z     <= shadow[47:32];
              data_valid <= 1'b1;
              state      <= ST_PUBLISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD_REQ;
            end
          end
        end

        ST_PUBLISH: begin
          state <= ST_POLL_IDLE;
        end

        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsensor_spi_ctrl.sv
// tb/tb_gsensor_spi_ctrl.sv - self-checking bench for gsensor_spi_ctrl with a spi_serdes mimic
`timescale 1ns/1ps
module tb_gsensor_spi_ctrl;

  localparam int INIT_DELAY    = 20;
  localparam int UPDATE_PERIOD = 50;

  logic        spi_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start;
  logic [15:0] data_tx;
  logic        done    = 1'b0;
  logic [7:0]  data_rx = 8'h00;
  logic        init_done;
  logic [15:0] data_x, data_y, data_z;
  logic        data_valid;
  logic        overrun;
`ifdef GSENSOR_INT_EN
  logic        int1 = 1'b0;
`endif

  always #250 spi_clk = ~spi_clk;

  gsensor_spi_ctrl #(
    .UPDATE_PERIOD(UPDATE_PERIOD),
    .INIT_DELAY   (INIT_DELAY)
  ) dut (
    .spi_clk      (spi_clk),
    .reset_n      (reset_n),
    .start        (start),
    .data_tx      (data_tx),
    .done         (done),
    .data_rx      (data_rx),
    .init_done    (init_done),
    .data_x       (data_x),
    .data_y       (data_y),
    .data_z       (data_z),
    .data_valid   (data_valid),
`ifdef GSENSOR_INT_EN
    .G_SENSOR_INT1(int1),
`endif
    .overrun      (overrun)
  );

  typedef struct {
    logic [15:0] tx;
    logic [7:0]  rx;
  } vec_t;

  vec_t        vec[11];
  int          n_vec = 0;
  int          n_bad = 0;
  int          valid_seen = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name, output bit ok);
    int w = 0;
    while (start !== 1'b1 && w < 2000) begin
      @(negedge spi_clk);
      w++;
    end
    ok = (start === 1'b1);
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: timeout waiting for start", name);
    end
  endtask

  // spi_serdes mimic for one transaction: done high for two cycles after lat cycles.
  task automatic serve(input string name, input logic [15:0] tx, input logic [7:0] rx,
                       input int lat);
    bit ok;
    wait_start(name, ok);
    if (ok) begin
      check(name, data_tx, tx);
      repeat (lat) @(negedge spi_clk);
      done    = 1'b1;
      data_rx = rx;
      @(negedge spi_clk);
      check({name, "_start_drop"}, start, 1'b0);
      @(negedge spi_clk);
      done    = 1'b0;
      data_rx = 8'h00;
    end
  endtask

  // bytes[8i+:8] is the byte returned for register 0x32+i, so {z,y,x} equals bytes.
  task automatic burst(input logic [47:0] bytes, input int lat);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) exp_q.push_back(bytes);
      serve($sformatf("rd%0d", i), 16'hB200 + 16'(i << 8), bytes[8*i +: 8], lat);
    end
  endtask

  task automatic wait_valid(input int target);
    int w = 0;
    while (valid_seen < target && w < 500) begin
      @(negedge spi_clk);
      w++;
    end
    check("valid_count", valid_seen, target);
  endtask

  task automatic run_init_and_first_burst();
    for (int i = 0; i < 11; i++) begin
      if (i == 10) exp_q.push_back(48'h5678_ABCD_1234);
      serve($sformatf("vec%0d", i), vec[i].tx, vec[i].rx, 1);
      if (i == 4) begin
        check("init_done_early", init_done, 1'b0);
        @(negedge spi_clk);
        check("init_done", init_done, 1'b1);
      end
    end
  endtask

  // Sample monitor: every data_valid pulse must match the oldest expected sample.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge spi_clk);
      if (data_valid === 1'b1) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_valid: got sample %0h with none expected",
                   {data_z, data_y, data_x});
        end else begin
          e = exp_q.pop_front();
          check("sample", {data_z, data_y, data_x}, e);
        end
      end
    end
  end

`ifdef GSENSOR_INT_EN
  // INT1 pulses emulating a DATA_READY period, plus one pulse before init completes.
  initial begin
    int c;
    repeat (5) @(negedge spi_clk);
    int1 = 1'b1;
    repeat (3) @(negedge spi_clk);
    int1 = 1'b0;
    forever begin
      wait (init_done === 1'b1);
      c = 0;
      while (init_done === 1'b1) begin
        @(negedge spi_clk);
        c++;
        if (c % UPDATE_PERIOD == UPDATE_PERIOD - 4) int1 = 1'b1;
        if (c % UPDATE_PERIOD == UPDATE_PERIOD - 1) int1 = 1'b0;
      end
      int1 = 1'b0;
    end
  end
`endif

  initial begin
    int  w;
    bit  ok;

    vec[0]  = '{16'h310B, 8'h00};
    vec[1]  = '{16'h2C0A, 8'h00};
    vec[2]  = '{16'h2F00, 8'h00};
`ifdef GSENSOR_INT_EN
    vec[3]  = '{16'h2E80, 8'h00};
`else
    vec[3]  = '{16'h2E00, 8'h00};
`endif
    vec[4]  = '{16'h2D08, 8'h00};
    vec[5]  = '{16'hB200, 8'h34};
    vec[6]  = '{16'hB300, 8'h12};
    vec[7]  = '{16'hB400, 8'hCD};
    vec[8]  = '{16'hB500, 8'hAB};
    vec[9]  = '{16'hB600, 8'h78};
    vec[10] = '{16'hB700, 8'h56};

    // Reset state
    repeat (3) @(negedge spi_clk);
    check("rst_start",      start,      1'b0);
    check("rst_data_tx",    data_tx,    16'h0000);
    check("rst_init_done",  init_done,  1'b0);
    check("rst_data_x",     data_x,     16'h0000);
    check("rst_data_y",     data_y,     16'h0000);
    check("rst_data_z",     data_z,     16'h0000);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_overrun",    overrun,    1'b0);

    // Boot delay before the first init write
    reset_n = 1'b1;
    w = 0;
    while (start !== 1'b1 && w < 200) begin
      @(negedge spi_clk);
      w++;
    end
    check("boot_delay_in_range", (w >= INIT_DELAY) && (w <= INIT_DELAY + 2), 1'b1);

    // Init table and first burst
    run_init_and_first_burst();
    wait_valid(1);
    check("data_x", data_x, 16'h1234);
    check("data_y", data_y, 16'hABCD);
    check("data_z", data_z, 16'h5678);
    check("overrun_after_first", overrun, 1'b0);

    // Slow bursts: one trigger queued during a burst, then a second one lost
    burst(48'h0102_0304_0506, 10);
    w = 0;
    while (start !== 1'b1 && w < 40) begin
      @(negedge spi_clk);
      w++;
    end
    check("pending_b2b_start", w <= 5, 1'b1);
    check("overrun_one_pending", overrun, 1'b0);
    burst(48'hF0E1_D2C3_B4A5, 10);
    wait_valid(3);
    check("overrun_set", overrun, 1'b1);

    // Reset during read idx 3 of the queued burst
    serve("rd0_abort", 16'hB200, 8'h11, 1);
    serve("rd1_abort", 16'hB300, 8'h22, 1);
    serve("rd2_abort", 16'hB400, 8'h33, 1);
    wait_start("rd3_abort", ok);
    check("rd3_abort_tx", data_tx, 16'hB500);
    reset_n = 1'b0;
    #1;
    check("abort_start",     start,     1'b0);
    check("abort_init_done", init_done, 1'b0);
    check("abort_data_x",    data_x,    16'h0000);
    check("abort_data_z",    data_z,    16'h0000);
    check("abort_overrun",   overrun,   1'b0);
    repeat (3) @(negedge spi_clk);
    reset_n = 1'b1;

    // Full re-init and a clean burst after reset
    run_init_and_first_burst();
    wait_valid(4);
    check("data_x_after_reset", data_x, 16'h1234);
    check("overrun_after_reset", overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
